reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//   Shares the register file's single write port between two writeback requesters:
//   A = ALU result, B = memory load.
//   Round-robin arbitration with a VALID/READY handshake per requester.
//   Registered outputs drive the register file's WRITE/INADDRESS/IN pins.
//   Also sequences a software clear that writes zero to every register, one per cycle.
// PARAMETERS
//   DATA_WIDTH  8  width of write data
//   ADDR_WIDTH  3  width of register address
//   NUM_REGS    8  registers zeroed by a clear sequence (must be <= 2**ADDR_WIDTH)
// PORTS
//   CLK         in   1           clock, all state changes on rising edge
//   RESET       in   1           asynchronous, active-high reset
//   A_VALID     in   1           requester A has a write pending
//   A_ADDR      in   ADDR_WIDTH  requester A destination register
//   A_DATA      in   DATA_WIDTH  requester A write data
//   A_READY     out  1           A's request accepted this cycle (combinational)
//   B_VALID     in   1           requester B has a write pending
//   B_ADDR      in   ADDR_WIDTH  requester B destination register
//   B_DATA      in   DATA_WIDTH  requester B write data
//   B_READY     out  1           B's request accepted this cycle (combinational)
//   CLEAR_REQ   in   1           start clear sequence (level, sampled at rising edge)
//   BUSY        out  1           high while in CLEAR state
//   CLEAR_DONE  out  1           one-cycle pulse after the last clear write
//   WR_EN       out  1           to register file WRITE (registered)
//   WR_ADDR     out  ADDR_WIDTH  to register file INADDRESS (registered)
//   WR_DATA     out  DATA_WIDTH  to register file IN (registered)
// BEHAVIOUR
//   Reset (async, immediate)
//     - state=RUN; WR_EN=0, WR_ADDR=0, WR_DATA=0, CLEAR_DONE=0, BUSY=0.
//     - last-grant pointer = B, so A wins the first tie.
//     - Reset during CLEAR aborts the sequence with no CLEAR_DONE pulse.
//   States: RUN, CLEAR. BUSY = (state==CLEAR).
//   RUN, grant (combinational)
//     - If CLEAR_REQ=1: A_READY=B_READY=0.
//     - Else, only one VALID high: that requester gets READY.
//     - Else, both VALID high: the requester not granted last gets READY.
//     - Never both READY in the same cycle.
//   Transfer = VALID&&READY at a rising edge k.
//     - At edge k: WR_EN<=1, WR_ADDR<=ADDR, WR_DATA<=DATA, pointer<=winner.
//     - Register file commits at edge k+1. Latency is one cycle; throughput is one write/cycle.
//     - No transfer at an edge (RUN): WR_EN<=0; WR_ADDR/WR_DATA hold their values.
//   Requester rules
//     - Holds VALID, ADDR, DATA stable until it sees READY.
//     - May drop VALID only after a transfer.
//   Same-address requests from A and B: still arbitrated; writes land in grant order.
//   RUN -> CLEAR: edge with CLEAR_REQ=1 in RUN. At that edge WR_EN<=1, WR_ADDR<=0, WR_DATA<=0.
//     - A write accepted at the previous edge still commits at this edge; ordering is preserved.
//   CLEAR
//     - A_READY=B_READY=0; CLEAR_REQ is ignored.
//     - Each edge: WR_ADDR<=WR_ADDR+1 with WR_EN=1, WR_DATA=0.
//     - Edge where WR_ADDR==NUM_REGS-1: state<=RUN, WR_EN<=0, CLEAR_DONE<=1.
//     - Net effect: addresses 0..NUM_REGS-1 are written in NUM_REGS consecutive cycles.
//   CLEAR_DONE: high for exactly one cycle. RUN arbitration is live in that same cycle.
//   CLEAR_REQ still high on return to RUN: starts a new clear (level-sensitive).
//   WR_ADDR never wraps past NUM_REGS-1 in CLEAR.
// TESTING
//   1. Reset mid-clear: assert RESET at clear cycle 3.
//      -> WR_EN=0, BUSY=0 immediately; no CLEAR_DONE.
//   2. A only: A_VALID=1, A_ADDR=5, A_DATA=0x3C.
//      -> A_READY=1 same cycle; next cycle WR_EN=1, WR_ADDR=5, WR_DATA=0x3C.
//      -> reg file OUT1@addr5 = 0x3C.
//   3. Both valid for 4 cycles after reset (A: 1/0x11, 2/0x22; B: 3/0x33, 4/0x44).
//      -> grants A,B,A,B; WR_ADDR sequence 1,3,2,4 on consecutive cycles.
//   4. Same-address tie: A(6,0xAA), B(6,0xBB), pointer=B.
//      -> A written first, then B; register 6 ends 0xBB.
//   5. CLEAR_REQ pulse with A_VALID held.
//      -> A_READY=0 for 9 cycles; WR_ADDR 0..7 with WR_DATA=0; CLEAR_DONE one pulse.
//      -> A accepted in the CLEAR_DONE cycle.
//   6. CLEAR_REQ one cycle after accepting B(2,0x77).
//      -> 0x77 commits to reg 2, then the clear zeroes it; final reg 2 = 0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Shares the register file's single write port between two writeback
//   requesters: A (ALU result) and B (memory load). Round-robin grant with a
//   VALID/READY handshake per requester; registered WR_* outputs drive the
//   register file's WRITE/INADDRESS/IN pins. Also runs a software clear that
//   writes zero to registers 0..NUM_REGS-1, one per cycle.
//
// Ports
//   CLK, RESET                  clock, asynchronous active-high reset
//   A_VALID/A_ADDR/A_DATA       requester A write request
//   A_READY                     A accepted this cycle (combinational)
//   B_VALID/B_ADDR/B_DATA       requester B write request
//   B_READY                     B accepted this cycle (combinational)
//   CLEAR_REQ                   start clear sequence (level)
//   BUSY                        high while clearing
//   CLEAR_DONE                  one-cycle pulse after the last clear write
//   WR_EN/WR_ADDR/WR_DATA       registered register-file write port
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | arbitrate A/B writes; CLEAR_REQ blocks grants and starts a clear
// CLEAR | write zero to WR_ADDR each cycle, stepping up to NUM_REGS-1

module reg_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  A_VALID,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_DATA,
    output logic                  A_READY,
    input  logic                  B_VALID,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_DATA,
    output logic                  B_READY,
    input  logic                  CLEAR_REQ,
    output logic                  BUSY,
    output logic                  CLEAR_DONE,
    output logic                  WR_EN,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic [DATA_WIDTH-1:0] WR_DATA
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                  state, state_nxt;
    logic                    last_b, last_b_nxt;   // 1: B was granted most recently
    logic                    wr_en_nxt;
    logic [ADDR_WIDTH-1:0]   wr_addr_nxt;
    logic [DATA_WIDTH-1:0]   wr_data_nxt;
    logic                    clear_done_nxt;

    assign BUSY = (state == ST_CLEAR);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_RUN;
            last_b     <= 1'b1;   // A wins the first tie
            WR_EN      <= 1'b0;
            WR_ADDR    <= '0;
            WR_DATA    <= '0;
            CLEAR_DONE <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_b     <= last_b_nxt;
            WR_EN      <= wr_en_nxt;
            WR_ADDR    <= wr_addr_nxt;
            WR_DATA    <= wr_data_nxt;
            CLEAR_DONE <= clear_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_b_nxt     = last_b;
        wr_en_nxt      = 1'b0;
        wr_addr_nxt    = WR_ADDR;
        wr_data_nxt    = WR_DATA;
        clear_done_nxt = 1'b0;
        A_READY        = 1'b0;
        B_READY        = 1'b0;

        case (state)
            ST_RUN: begin
                if (CLEAR_REQ) begin
                    // Any write accepted last edge is already on WR_*, so it
                    // commits ahead of the first clear write.
                    state_nxt   = ST_CLEAR;
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = '0;
                    wr_data_nxt = '0;
                end else begin
                    if (A_VALID && (!B_VALID || last_b)) begin
                        A_READY = 1'b1;
                    end else if (B_VALID) begin
                        B_READY = 1'b1;
                    end

                    if (A_READY) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = A_ADDR;
                        wr_data_nxt = A_DATA;
                        last_b_nxt  = 1'b0;
                    end else if (B_READY) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = B_ADDR;
                        wr_data_nxt = B_DATA;
                        last_b_nxt  = 1'b1;
                    end
                end
            end

            ST_CLEAR: begin
                if (WR_ADDR == LAST_ADDR) begin
                    // Last zero write is on the port now; address holds here.
                    state_nxt      = ST_RUN;
                    clear_done_nxt = 1'b1;
                end else begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = WR_ADDR + ADDR_WIDTH'(1);
                    wr_data_nxt = '0;
                end
            end

            default: state_nxt = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          A_VALID, B_VALID, CLEAR_REQ;
    logic [AW-1:0] A_ADDR, B_ADDR;
    logic [DW-1:0] A_DATA, B_DATA;
    logic          A_READY, B_READY, BUSY, CLEAR_DONE, WR_EN;
    logic [AW-1:0] WR_ADDR;
    logic [DW-1:0] WR_DATA;

    always #5 CLK = ~CLK;

    reg_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .CLK(CLK), .RESET(RESET),
        .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
        .B_VALID(B_VALID), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY),
        .CLEAR_REQ(CLEAR_REQ), .BUSY(BUSY), .CLEAR_DONE(CLEAR_DONE),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    bit mon_en    = 1'b0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_exp;
    logic [DW-1:0]    rf_model [NR];

    // Register file: commits on the edge after WR_EN is presented.
    always @(posedge CLK) if (WR_EN) rf_model[WR_ADDR] <= WR_DATA;

    // Scoreboard: every write on the port must match the next expected entry.
    always @(negedge CLK) begin
        if (CLEAR_DONE === 1'b1) done_cnt++;
        if (mon_en && WR_EN === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: got addr=%0d data=0x%02h, required no write",
                         WR_ADDR, WR_DATA);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({WR_ADDR, WR_DATA} !== mon_exp)
                    $display("FAIL write_order: got addr=%0d data=0x%02h, required addr=%0d data=0x%02h",
                             WR_ADDR, WR_DATA, mon_exp[AW+DW-1:DW], mon_exp[DW-1:0]);
                else
                    pass_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        A_VALID = 0; B_VALID = 0; CLEAR_REQ = 0;
        A_ADDR = '0; B_ADDR = '0; A_DATA = '0; B_DATA = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        RESET = 1'b1;
        #2;
        total_cnt++; if (WR_EN !== 1'b0) $display("FAIL reset_wr_en: got %b required 0", WR_EN); else pass_cnt++;
        total_cnt++; if (WR_ADDR !== 3'd0) $display("FAIL reset_wr_addr: got %0d required 0", WR_ADDR); else pass_cnt++;
        total_cnt++; if (WR_DATA !== 8'h00) $display("FAIL reset_wr_data: got 0x%02h required 0x00", WR_DATA); else pass_cnt++;
        total_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b required 0", BUSY); else pass_cnt++;
        total_cnt++; if (CLEAR_DONE !== 1'b0) $display("FAIL reset_clear_done: got %b required 0", CLEAR_DONE); else pass_cnt++;
        tick();
        RESET = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset_mid_clear;
        int done_base;
        mon_en = 1'b0;
        CLEAR_REQ = 1'b1;
        tick();
        CLEAR_REQ = 1'b0;
        repeat (3) tick();
        #1;
        total_cnt++;
        if (BUSY !== 1'b1 || WR_ADDR !== 3'd3)
            $display("FAIL midclear_progress: got busy=%b addr=%0d required busy=1 addr=3", BUSY, WR_ADDR);
        else pass_cnt++;
        RESET = 1'b1;
        #1;
        total_cnt++; if (WR_EN !== 1'b0) $display("FAIL midclear_reset_wr_en: got %b required 0", WR_EN); else pass_cnt++;
        total_cnt++; if (BUSY !== 1'b0) $display("FAIL midclear_reset_busy: got %b required 0", BUSY); else pass_cnt++;
        done_base = done_cnt;
        tick();
        tick();
        RESET = 1'b0;
        repeat (12) tick();
        total_cnt++;
        if (done_cnt != done_base || BUSY !== 1'b0)
            $display("FAIL midclear_no_done: got pulses=%0d busy=%b required pulses=0 busy=0", done_cnt - done_base, BUSY);
        else pass_cnt++;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic test_a_only;
        do_reset();
        A_VALID = 1; A_ADDR = 3'd5; A_DATA = 8'h3C;
        #1;
        total_cnt++;
        if (A_READY !== 1'b1 || B_READY !== 1'b0)
            $display("FAIL a_only_ready: got a=%b b=%b required a=1 b=0", A_READY, B_READY);
        else pass_cnt++;
        exp_q.push_back({3'd5, 8'h3C});
        tick();
        A_VALID = 0;
        #1;
        total_cnt++;
        if (WR_EN !== 1'b1 || WR_ADDR !== 3'd5 || WR_DATA !== 8'h3C)
            $display("FAIL a_only_port: got en=%b addr=%0d data=0x%02h required en=1 addr=5 data=0x3c", WR_EN, WR_ADDR, WR_DATA);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (rf_model[5] !== 8'h3C) $display("FAIL a_only_regfile: got 0x%02h required 0x3c", rf_model[5]);
        else pass_cnt++;
        total_cnt++;
        if (WR_EN !== 1'b0) $display("FAIL a_only_idle: got %b required 0", WR_EN);
        else pass_cnt++;
    endtask

    task automatic test_both_round_robin;
        logic [AW-1:0] a_addr [2] = '{3'd1, 3'd2};
        logic [DW-1:0] a_data [2] = '{8'h11, 8'h22};
        logic [AW-1:0] b_addr [2] = '{3'd3, 3'd4};
        logic [DW-1:0] b_data [2] = '{8'h33, 8'h44};
        int  ai = 0, bi = 0;
        bit  ptr_b = 1'b1;
        bit  win_a;
        do_reset();
        for (int cyc = 0; cyc < 8 && (ai < 2 || bi < 2); cyc++) begin
            A_VALID = (ai < 2);
            B_VALID = (bi < 2);
            if (ai < 2) begin A_ADDR = a_addr[ai]; A_DATA = a_data[ai]; end
            if (bi < 2) begin B_ADDR = b_addr[bi]; B_DATA = b_data[bi]; end
            win_a = (A_VALID && B_VALID) ? ptr_b : A_VALID;
            #1;
            total_cnt++;
            if (A_READY !== win_a || B_READY !== !win_a)
                $display("FAIL both_grant_%0d: got a=%b b=%b required a=%b b=%b", cyc, A_READY, B_READY, win_a, !win_a);
            else pass_cnt++;
            if (win_a) begin
                exp_q.push_back({a_addr[ai], a_data[ai]}); ai++; ptr_b = 1'b0;
            end else begin
                exp_q.push_back({b_addr[bi], b_data[bi]}); bi++; ptr_b = 1'b1;
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL both_drain: got %0d pending required 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_same_addr;
        do_reset();
        A_VALID = 1; A_ADDR = 3'd6; A_DATA = 8'hAA;
        B_VALID = 1; B_ADDR = 3'd6; B_DATA = 8'hBB;
        #1;
        total_cnt++;
        if (A_READY !== 1'b1 || B_READY !== 1'b0)
            $display("FAIL same_addr_first: got a=%b b=%b required a=1 b=0", A_READY, B_READY);
        else pass_cnt++;
        exp_q.push_back({3'd6, 8'hAA});
        tick();
        A_VALID = 0;
        #1;
        total_cnt++;
        if (B_READY !== 1'b1) $display("FAIL same_addr_second: got b=%b required 1", B_READY);
        else pass_cnt++;
        exp_q.push_back({3'd6, 8'hBB});
        tick();
        B_VALID = 0;
        tick();
        tick();
        total_cnt++;
        if (rf_model[6] !== 8'hBB) $display("FAIL same_addr_final: got 0x%02h required 0xbb", rf_model[6]);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL same_addr_drain: got %0d pending required 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_clear_pulse;
        int  blocked = 0;
        bit  got = 0;
        int  done_base;
        done_base = done_cnt;
        A_VALID = 1; A_ADDR = 3'd1; A_DATA = 8'h5A;
        CLEAR_REQ = 1;
        for (int i = 0; i < NR; i++) exp_q.push_back({AW'(i), 8'h00});
        for (int c = 0; c < 20; c++) begin
            #1;
            if (A_READY === 1'b1) begin
                got = 1;
                break;
            end
            if (blocked == 4) begin
                total_cnt++;
                if (BUSY !== 1'b1) $display("FAIL clear_busy: got %b required 1", BUSY);
                else pass_cnt++;
            end
            blocked++;
            tick();
            CLEAR_REQ = 0;
        end
        total_cnt++;
        if (!got || blocked != 9)
            $display("FAIL clear_blocked_cycles: got %0d (accepted=%0d) required 9", blocked, got);
        else pass_cnt++;
        total_cnt++;
        if (CLEAR_DONE !== 1'b1) $display("FAIL clear_done_with_accept: got %b required 1", CLEAR_DONE);
        else pass_cnt++;
        if (got) exp_q.push_back({3'd1, 8'h5A});
        tick();
        A_VALID = 0;
        #1;
        total_cnt++;
        if (CLEAR_DONE !== 1'b0) $display("FAIL clear_done_width: got %b required 0", CLEAR_DONE);
        else pass_cnt++;
        repeat (3) tick();
        total_cnt++;
        if (done_cnt - done_base != 1) $display("FAIL clear_done_count: got %0d required 1", done_cnt - done_base);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL clear_drain: got %0d pending required 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_clear_after_write;
        int waited = 0;
        B_VALID = 1; B_ADDR = 3'd2; B_DATA = 8'h77;
        #1;
        total_cnt++;
        if (B_READY !== 1'b1) $display("FAIL cw_b_ready: got %b required 1", B_READY);
        else pass_cnt++;
        exp_q.push_back({3'd2, 8'h77});
        tick();
        B_VALID = 0;
        CLEAR_REQ = 1;
        for (int i = 0; i < NR; i++) exp_q.push_back({AW'(i), 8'h00});
        tick();
        CLEAR_REQ = 0;
        #1;
        total_cnt++;
        if (rf_model[2] !== 8'h77) $display("FAIL cw_commit_first: got 0x%02h required 0x77", rf_model[2]);
        else pass_cnt++;
        total_cnt++;
        if (BUSY !== 1'b1) $display("FAIL cw_busy: got %b required 1", BUSY);
        else pass_cnt++;
        while (BUSY === 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        total_cnt++;
        if (BUSY !== 1'b0) $display("FAIL cw_clear_ends: got busy=%b after %0d cycles required 0", BUSY, waited);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (rf_model[2] !== 8'h00) $display("FAIL cw_final_reg2: got 0x%02h required 0x00", rf_model[2]);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL cw_drain: got %0d pending required 0", exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_clear();
        test_a_only();
        test_both_round_robin();
        test_same_addr();
        test_clear_pulse();
        test_clear_after_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
